usb_tx_phy: RTL

//  Byte-to-line transmit stage of the USB device; sits directly downstream of the tx packet FSM.

---
 rtl/usb_tx_phy_pkg.sv | 21 ++
 rtl/usb_tx_phy_if.sv | 11 +
 rtl/usb_tx_phy_nrzi_stuffer.sv | 35 +++
 rtl/usb_tx_phy.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/usb_tx_phy_pkg.sv
// Shared types and constants for the USB transmit PHY: FSM states, line codes and stuffing limit.
package usb_tx_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

  // Line codes packed as {dp, dn}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int unsigned STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_tx_phy_if.sv
// Byte handshake between the tx packet FSM (master) and the transmit PHY (slave).
interface usb_tx_phy_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/usb_tx_phy_nrzi_stuffer.sv
// Tracks consecutive transmitted ones for bit stuffing and holds the NRZI line level (1 = J).
module usb_tx_phy_nrzi_stuffer
  import usb_tx_phy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_advance,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_levelNext,
  output logic o_stuffPending
);

  logic [2:0] r_ones;
  logic       r_level;

  assign o_stuffPending = (r_ones == 3'(STUFF_LIMIT));

  // A zero on the wire is a level change; the top registers this same value onto dp/dn
  assign o_levelNext = (i_advance && !i_bit) ? ~r_level : r_level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ones  <= '0;
      r_level <= 1'b1;
    end else if (i_clear) begin
      r_ones  <= '0;
      r_level <= 1'b1;
    end else if (i_advance) begin
      r_level <= o_levelNext;
      r_ones  <= i_bit ? r_ones + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/usb_tx_phy.sv
// USB transmit PHY: SYNC prefix, LSB-first serialisation, bit stuffing, NRZI and EOP on dp/dn/oe.
module usb_tx_phy
  import usb_tx_phy_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  usb_tx_phy_if.slave txIf,
  output logic        o_dp,
  output logic        o_dn,
  output logic        o_oe,
  output logic        o_busy
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [6:0]       r_shift;
  logic             r_dp;
  logic             r_dn;
  logic             r_oe;
  logic             r_busy;

  logic w_bitStb;
  logic w_inPacket;
  logic w_stuffPending;
  logic w_levelNext;
  logic w_advance;
  logic w_bit;
  logic w_clear;
  logic w_txReady;

  assign w_bitStb   = (r_cnt == CNT_LAST);
  assign w_inPacket = (r_state == ST_SYNC) || (r_state == ST_DATA);
  assign w_txReady  = w_bitStb && w_inPacket && (r_bitIdx == 3'd7) && !w_stuffPending;

  assign txIf.tx_ready = w_txReady;
  assign o_dp          = r_dp;
  assign o_dn          = r_dn;
  assign o_oe          = r_oe;
  assign o_busy        = r_busy;

  // Decide what the next bit slot carries: a SYNC/data bit, a stuffed zero, or the start of EOP
  always_comb begin
    w_advance = 1'b0;
    w_bit     = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (txIf.tx_valid) begin
          w_advance = 1'b1;
          w_bit     = SYNC_BYTE[0];
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_bitStb) begin
          if (w_stuffPending) begin
            w_advance = 1'b1;
          end else if (r_bitIdx != 3'd7) begin
            w_advance = 1'b1;
            w_bit     = r_shift[0];
          end else if (txIf.tx_valid) begin
            w_advance = 1'b1;
            w_bit     = txIf.tx_data[0];
          end else begin
            w_clear = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  usb_tx_phy_nrzi_stuffer u_stuffer (
    .clk            (clk),
    .reset          (reset),
    .i_advance      (w_advance),
    .i_bit          (w_bit),
    .i_clear        (w_clear),
    .o_levelNext    (w_levelNext),
    .o_stuffPending (w_stuffPending)
  );

  // r_shift holds the not-yet-sent upper bits; during EOP r_bitIdx counts SE0 bit periods
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_dp     <= 1'b1;
      r_dn     <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (txIf.tx_valid) begin
            r_state      <= ST_SYNC;
            r_shift      <= SYNC_BYTE[7:1];
            r_bitIdx     <= '0;
            r_oe         <= 1'b1;
            r_busy       <= 1'b1;
            {r_dp, r_dn} <= w_levelNext ? LINE_J : LINE_K;
          end
        end
        ST_SYNC, ST_DATA: begin
          r_cnt <= w_bitStb ? '0 : r_cnt + 1'b1;
          if (w_bitStb) begin
            if (w_clear) begin
              r_state      <= ST_EOP_SE0;
              r_bitIdx     <= '0;
              {r_dp, r_dn} <= LINE_SE0;
            end else begin
              {r_dp, r_dn} <= w_levelNext ? LINE_J : LINE_K;
              if (!w_stuffPending) begin
                if (r_bitIdx != 3'd7) begin
                  r_shift  <= r_shift >> 1;
                  r_bitIdx <= r_bitIdx + 3'd1;
                end else begin
                  r_shift  <= txIf.tx_data[7:1];
                  r_bitIdx <= '0;
                  r_state  <= ST_DATA;
                end
              end
            end
          end
        end
        ST_EOP_SE0: begin
          r_cnt <= w_bitStb ? '0 : r_cnt + 1'b1;
          if (w_bitStb) begin
            if (r_bitIdx == 3'd1) begin
              r_state      <= ST_EOP_J;
              r_bitIdx     <= '0;
              {r_dp, r_dn} <= LINE_J;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          r_cnt <= w_bitStb ? '0 : r_cnt + 1'b1;
          if (w_bitStb) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
